alu_req_scheduler: RTL and testbench

Round-robin scheduler sharing one low-power 16-bit ALU among NUM_REQ requesters. It accepts one operation at a time, drives the ALU operands and opcode, and asserts the ALU clock-gate enable only during the issue cycle. It returns the result, zero and carry to the winning requester. It also keeps power-analysis counters for completed operations and clock-gated cycles.

---
 rtl/alu_req_scheduler.sv | 150 +++++++++++++++
 tb/tb_alu_req_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - round-robin scheduler sharing one 16-bit ALU
//
// Grants one requester at a time (round-robin from rr_ptr). It drives the
// ALU operands and opcode, and enables the ALU for the single issue cycle.
// The registered ALU result is returned with a one-cycle resp_valid pulse.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester request handshake (ready is one-hot)
//   req_a/req_b/req_op   packed per-requester payload (16/16/3 bits each)
//   resp_*               response pulse, owner id, result, zero, carry
//   alu_a/alu_b/alu_op   operands and opcode to the ALU (held between ops)
//   alu_enable           ALU clock-gate / operand-isolation enable
//   alu_result/flag      registered ALU outputs
//   op_count             completed operations (saturating)
//   gated_cycles         cycles with alu_enable low (saturating)
module alu_req_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          resp_result,
  output logic                 resp_zero,
  output logic                 resp_carry,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_enable,
  input  logic [15:0]          alu_result,
  input  logic                 alu_carry_flag,
  output logic [15:0]          op_count,
  output logic [31:0]          gated_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] gnt_id_q;
  logic [15:0]    alu_a_q, alu_b_q;
  logic [2:0]     alu_op_q;
  logic           resp_valid_q;
  logic [IDW-1:0] resp_id_q;
  logic [15:0]    resp_result_q;
  logic           resp_zero_q, resp_carry_q;
  logic [15:0]    op_count_q;
  logic [31:0]    gated_cycles_q;

  logic           found;
  logic           grant;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;

  // Round-robin pick: first valid requester at or after rr_ptr. NUM_REQ is a
  // power of two, so the IDW-bit add wraps modulo NUM_REQ for free.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr_q + IDW'(i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grants are possible in IDLE and in CAPTURE (back-to-back), never in ISSUE.
  always_comb begin
    grant      = found && !rst && (state_q != S_ISSUE);
    req_ready  = '0;
    if (grant) begin
      req_ready[win] = 1'b1;
    end
    alu_enable = (state_q == S_ISSUE);
    state_d    = state_q;
    case (state_q)
      S_IDLE:    state_d = grant ? S_ISSUE : S_IDLE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = grant ? S_ISSUE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      gnt_id_q       <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_result_q  <= '0;
      resp_zero_q    <= 1'b0;
      resp_carry_q   <= 1'b0;
      op_count_q     <= '0;
      gated_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      // Operands only move on a grant so the ALU inputs stay quiet when idle.
      if (grant) begin
        alu_a_q  <= req_a[16*int'(win) +: 16];
        alu_b_q  <= req_b[16*int'(win) +: 16];
        alu_op_q <= req_op[3*int'(win) +: 3];
        gnt_id_q <= win;
        rr_ptr_q <= win + IDW'(1);
      end
      resp_valid_q <= (state_q == S_CAPTURE);
      if (state_q == S_CAPTURE) begin
        resp_id_q     <= gnt_id_q;
        resp_result_q <= alu_result;
        resp_zero_q   <= (alu_result == 16'h0000);
        resp_carry_q  <= alu_carry_flag;
        if (op_count_q != 16'hFFFF) begin
          op_count_q <= op_count_q + 16'd1;
        end
      end
      if (!alu_enable && gated_cycles_q != 32'hFFFF_FFFF) begin
        gated_cycles_q <= gated_cycles_q + 32'd1;
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_result  = resp_result_q;
  assign resp_zero    = resp_zero_q;
  assign resp_carry   = resp_carry_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign op_count     = op_count_q;
  assign gated_cycles = gated_cycles_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - self-checking bench for alu_req_scheduler
module tb_alu_req_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic [3*N-1:0]  req_op;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [15:0]     resp_result;
  logic            resp_zero, resp_carry;
  logic [15:0]     alu_a, alu_b;
  logic [2:0]      alu_op;
  logic            alu_enable;
  logic [15:0]     alu_result = '0;
  logic            alu_carry_flag = 1'b0;
  logic [15:0]     op_count;
  logic [31:0]     gated_cycles;

  int checks   = 0;
  int failures = 0;
  int opcnt_exp = 0;

  always #5 clk = ~clk;

  alu_req_scheduler #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_carry(resp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_carry_flag(alu_carry_flag),
    .op_count(op_count), .gated_cycles(gated_cycles)
  );

  // Reference ALU: {carry, result}. ADD carry-out, SUB borrow, MUL overflow.
  function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0000, a} * {16'h0000, b};
    case (op)
      3'd0:    alu_fn = {1'b0, a} + {1'b0, b};
      3'd1:    alu_fn = {(a < b), a - b};
      3'd2:    alu_fn = {1'b0, a & b};
      3'd3:    alu_fn = {1'b0, a | b};
      3'd4:    alu_fn = {1'b0, a ^ b};
      3'd5:    alu_fn = {1'b0, a << b[3:0]};
      3'd6:    alu_fn = {1'b0, a >> b[3:0]};
      default: alu_fn = {(p[31:16] != 16'h0000), p[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_enable) {alu_carry_flag, alu_result} <= alu_fn(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_valid[id]       = 1'b1;
    req_a[16*id +: 16]  = a;
    req_b[16*id +: 16]  = b;
    req_op[3*id +: 3]   = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    opcnt_exp = 0;
  endtask

  // One isolated operation starting from IDLE, granted in cycle 0.
  task automatic do_op(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic z, input logic c);
    set_req(id, op, a, b);
    @(negedge clk);
    chk("op_ready", 32'(req_ready), 32'(1 << id));
    chk("op_en_grant", 32'(alu_enable), 0);
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    chk("op_en_issue", 32'(alu_enable), 1);
    chk("op_alu_a", 32'(alu_a), 32'(a));
    chk("op_alu_b", 32'(alu_b), 32'(b));
    chk("op_alu_op", 32'(alu_op), 32'(op));
    chk("op_rv_issue", 32'(resp_valid), 0);
    @(negedge clk);
    chk("op_en_capture", 32'(alu_enable), 0);
    chk("op_rv_capture", 32'(resp_valid), 0);
    @(negedge clk);
    chk("op_rv", 32'(resp_valid), 1);
    chk("op_id", 32'(resp_id), 32'(id));
    chk("op_result", 32'(resp_result), 32'(res));
    chk("op_zero", 32'(resp_zero), 32'(z));
    chk("op_carry", 32'(resp_carry), 32'(c));
    opcnt_exp++;
    chk("op_count", 32'(op_count), 32'(opcnt_exp));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        z, c;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic [15:0] res;
    logic        z, c;
  } exp_t;

  // Transaction-level model state for the random test.
  int          m_cyc, m_last_g, m_ptr, m_op, m_gated;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_opc;
  exp_t        m_rq[$];
  logic [N-1:0] acked;

  task automatic model_reset();
    m_cyc = 0; m_last_g = -100; m_ptr = 0; m_op = 0; m_gated = 0;
    m_a = '0; m_b = '0; m_opc = '0;
    m_rq.delete();
    acked = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] exp_ready;
    logic [16:0]  r;
    logic         exp_en, exp_rv;
    int           win, j;
    exp_t         e;
    exp_ready = '0;
    win = -1;
    if (m_cyc - m_last_g >= 2) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && req_valid[j]) win = j;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
    exp_en = (m_cyc == m_last_g + 1);
    chk("rnd_enable", 32'(alu_enable), 32'(exp_en));
    chk("rnd_alu_a", 32'(alu_a), 32'(m_a));
    chk("rnd_alu_b", 32'(alu_b), 32'(m_b));
    chk("rnd_alu_op", 32'(alu_op), 32'(m_opc));
    exp_rv = (m_rq.size() > 0) && (m_rq[0].due == m_cyc);
    chk("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (exp_rv) begin
      e = m_rq.pop_front();
      m_op++;
      chk("rnd_resp_id", 32'(resp_id), 32'(e.id));
      chk("rnd_resp_result", 32'(resp_result), 32'(e.res));
      chk("rnd_resp_zero", 32'(resp_zero), 32'(e.z));
      chk("rnd_resp_carry", 32'(resp_carry), 32'(e.c));
    end
    chk("rnd_op_count", 32'(op_count), 32'(m_op));
    chk("rnd_gated", gated_cycles, 32'(m_gated));
    if (win >= 0) begin
      m_last_g = m_cyc;
      m_ptr    = (win + 1) % N;
      m_a      = req_a[16*win +: 16];
      m_b      = req_b[16*win +: 16];
      m_opc    = req_op[3*win +: 3];
      r        = alu_fn(m_opc, m_a, m_b);
      e.due = m_cyc + 3; e.id = win; e.res = r[15:0]; e.z = (r[15:0] == 16'h0000); e.c = r[16];
      m_rq.push_back(e);
      acked[win] = 1'b1;
    end
    if (!exp_en) m_gated++;
    m_cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    logic [N-1:0] pend;
    logic [15:0]  rr_res;
    int           density, g;
    logic         rst_now;

    vecs[0] = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1};
    vecs[1] = '{3'd5, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0};
    vecs[2] = '{3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{3'd4, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    vecs[5] = '{3'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0};
    vecs[6] = '{3'd6, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{3'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};

    // Reset state and ready forced low while rst is high.
    clear_inputs();
    rst = 1'b1;
    req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_result", 32'(resp_result), 0);
    chk("rst_resp_zero", 32'(resp_zero), 0);
    chk("rst_resp_carry", 32'(resp_carry), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_gated", gated_cycles, 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_enable", 32'(alu_enable), 0);

    // Idle gating: 10 idle cycles after reset.
    @(posedge clk); #1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      chk("idle_enable", 32'(alu_enable), 0);
      chk("idle_alu_a", 32'(alu_a), 0);
      chk("idle_alu_b", 32'(alu_b), 0);
      chk("idle_alu_op", 32'(alu_op), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("idle_gated10", gated_cycles, 32'd10);
    @(posedge clk); #1;

    // Single ADD via requester 1.
    do_reset();
    do_op(1, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);

    // Opcode sweep via requester 2.
    for (int i = 0; i < 8; i++) begin
      do_op(2, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].c);
    end

    // Round-robin fairness under full load.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 16'(16'h0100 * (i + 1)), 16'(i));
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), (c % 2 == 0) ? 32'(1 << ((c / 2) % N)) : 32'd0);
      chk("rr_enable", 32'(alu_enable), 32'(c % 2));
      if (c >= 3 && (c % 2) == 1) begin
        g = ((c - 3) / 2) % N;
        rr_res = 16'(16'h0100 * (g + 1) + g);
        chk("rr_resp_valid", 32'(resp_valid), 1);
        chk("rr_resp_id", 32'(resp_id), 32'(g));
        chk("rr_resp_result", 32'(resp_result), 32'(rr_res));
      end else begin
        chk("rr_resp_idle", 32'(resp_valid), 0);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    repeat (4) @(posedge clk);
    #1;

    // Reset during ISSUE abandons the op; pointer returns to requester 0.
    do_reset();
    set_req(0, 3'd0, 16'h0005, 16'h0006);
    @(negedge clk);
    chk("mid_first_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_issue_enable", 32'(alu_enable), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 3'd0, 16'h0007, 16'h0008);
    set_req(1, 3'd0, 16'h0001, 16'h0001);
    @(negedge clk);
    chk("mid_regrant0", 32'(req_ready), 32'h1);
    chk("mid_rv0", 32'(resp_valid), 0);
    chk("mid_opcnt", 32'(op_count), 0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("mid_rv1", 32'(resp_valid), 0);
    @(negedge clk);
    chk("mid_rv2", 32'(resp_valid), 0);
    chk("mid_opcnt2", 32'(op_count), 0);
    @(negedge clk);
    chk("mid_rv3", 32'(resp_valid), 1);
    chk("mid_id3", 32'(resp_id), 0);
    chk("mid_res3", 32'(resp_result), 32'h000F);
    @(posedge clk); #1;

    // Late arrival during ISSUE is granted in the following CAPTURE cycle.
    do_reset();
    set_req(0, 3'd3, 16'h00F0, 16'h0F00);
    @(negedge clk);
    chk("late_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    clear_inputs();
    set_req(3, 3'd1, 16'h0010, 16'h0001);
    @(negedge clk);
    chk("late_issue_ready", 32'(req_ready), 0);
    chk("late_issue_en", 32'(alu_enable), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_capture_grant", 32'(req_ready), 32'h8);
    chk("late_capture_en", 32'(alu_enable), 0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("late_rv_first", 32'(resp_valid), 1);
    chk("late_id_first", 32'(resp_id), 0);
    chk("late_res_first", 32'(resp_result), 32'h0FF0);
    chk("late_en2", 32'(alu_enable), 1);
    @(negedge clk);
    chk("late_rv_gap", 32'(resp_valid), 0);
    @(negedge clk);
    chk("late_rv_second", 32'(resp_valid), 1);
    chk("late_id_second", 32'(resp_id), 3);
    chk("late_res_second", 32'(resp_result), 32'h000F);
    @(posedge clk); #1;

    // Randomized traffic against the transaction-level model.
    do_reset();
    model_reset();
    pend = '0;
    density = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) density = $urandom_range(0, 100);
      for (int i = 0; i < N; i++) begin
        if (acked[i]) begin
          pend[i] = 1'b0;
          req_valid[i] = 1'b0;
        end
        if (!pend[i] && $urandom_range(0, 99) < density) begin
          set_req(i, 3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 17)) : 16'($urandom));
          pend[i] = 1'b1;
        end
      end
      acked = '0;
      rst_now = ($urandom_range(0, 299) == 0);
      rst = rst_now;
      @(negedge clk);
      if (rst_now) chk("rnd_ready_in_reset", 32'(req_ready), 0);
      else model_step();
      @(posedge clk); #1;
      if (rst_now) begin
        model_reset();
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
